// File: rtl/legv8_mem_pkg.sv
// legv8_mem_pkg: shared encodings for the LEGv8 memory bus controller
//   size codes, fault codes, FSM states and byte-lane mask helpers
package legv8_mem_pkg;
    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;
    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_UNMAPPED = 2'b10,
        FAULT_RO_WRITE = 2'b11
    } fault_e;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;
    function automatic logic [7:0] be_mask(input logic [1:0] size);
        return size == SIZE_BYTE ? 8'h01 : size == SIZE_HALF ? 8'h03 : size == SIZE_WORD ? 8'h0F : 8'hFF;
    endfunction
    function automatic logic [63:0] bit_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) m[8*i+:8] = {8{be[i]}};
        return m;
    endfunction
endpackage

// File: rtl/legv8_region_decoder.sv
// legv8_region_decoder: combinational address-to-region decode
//   addr -> hit (any region matched), hit_idx (lowest matching region), ro (that region is read-only)
module legv8_region_decoder #(
    parameter int NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'h40000000, 32'h60000000},
    parameter logic [NUM_REGIONS*8-1:0] REGION_ABITS = {8'd10, 8'd12},
    parameter logic [NUM_REGIONS-1:0] REGION_RO = 2'b10
) (
    input  logic [31:0] addr,
    output logic        hit,
    output logic [1:0]  hit_idx,
    output logic        ro
);
    // Scanning from the top index down lets the lowest matching region overwrite the rest.
    always_comb begin
        hit = 1'b0;
        hit_idx = 2'd0;
        ro = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (((addr ^ REGION_BASE[32*i+:32]) >> REGION_ABITS[8*i+:8]) == 32'd0) begin
                hit = 1'b1;
                hit_idx = i[1:0];
                ro = REGION_RO[i];
            end
        end
    end
endmodule

// File: rtl/legv8_mem_bus_ctrl.sv
// legv8_mem_bus_ctrl: single-outstanding request bridge from a LEGv8 core to decoded memory regions
//   req_*  : request handshake with size/addr/right-aligned write data
//   rsp_*  : response handshake with zero-extended read data and fault code
//   mem_*  : one-hot region select, dword address, byte enables, lane-shifted write data, per-region read data
module legv8_mem_bus_ctrl
    import legv8_mem_pkg::*;
#(
    parameter int NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'h40000000, 32'h60000000},
    parameter logic [NUM_REGIONS*8-1:0] REGION_ABITS = {8'd10, 8'd12},
    parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = {4'd1, 4'd0},
    parameter logic [NUM_REGIONS-1:0] REGION_RO = 2'b10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic [31:0]               req_addr,
    input  logic [63:0]               req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [63:0]               rsp_rdata,
    output logic [1:0]                rsp_fault,
    output logic [NUM_REGIONS-1:0]    mem_sel,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [7:0]                mem_be,
    output logic [63:0]               mem_wdata,
    input  logic [NUM_REGIONS*64-1:0] mem_rdata
);
    state_e state_q, state_d;
    fault_e fault_q, fault_d;
    logic [31:0] addr_q;
    logic [1:0] size_q, idx_q, hit_idx;
    logic we_q, hit, ro, misalign, accept, acc;
    logic [63:0] wdata_q, rdata_q, rd_sel;
    logic [3:0] cnt_q, wait_sel;
    logic [NUM_REGIONS-1:0] sel_oh;

    legv8_region_decoder #(
        .NUM_REGIONS(NUM_REGIONS),
        .REGION_BASE(REGION_BASE),
        .REGION_ABITS(REGION_ABITS),
        .REGION_RO(REGION_RO)
    ) u_dec (
        .addr(req_addr),
        .hit(hit),
        .hit_idx(hit_idx),
        .ro(ro)
    );

    // (1 << size) - 1 wraps to 3'b111 for dwords, giving the low-address alignment mask for every size.
    assign misalign = |(req_addr[2:0] & ((3'd1 << req_size) - 3'd1));
    assign fault_d = misalign ? FAULT_MISALIGN : !hit ? FAULT_UNMAPPED : (ro && req_write) ? FAULT_RO_WRITE : FAULT_NONE;
    assign accept = state_q == IDLE && req_valid;
    assign acc = state_q == ACCESS;

    always_comb begin
        rd_sel = '0;
        wait_sel = '0;
        sel_oh = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (idx_q == i[1:0]) begin
                rd_sel = mem_rdata[64*i+:64];
                sel_oh[i] = 1'b1;
            end
            if (hit_idx == i[1:0]) wait_sel = REGION_WAIT[4*i+:4];
        end
    end

    always_comb begin
        state_d = state_q;
        state_d = accept ? (fault_d == FAULT_NONE ? ACCESS : RESP)
                : (acc && cnt_q == 4'd0) ? RESP
                : (state_q == RESP && rsp_ready) ? IDLE : state_q;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) state_q <= IDLE;
        else state_q <= state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            size_q <= '0;
            we_q <= 1'b0;
            wdata_q <= '0;
            idx_q <= '0;
            fault_q <= FAULT_NONE;
            cnt_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
            size_q <= req_size;
            we_q <= req_write;
            wdata_q <= req_wdata;
            idx_q <= hit_idx;
            fault_q <= fault_d;
            cnt_q <= wait_sel;
            rdata_q <= '0;
        end else if (acc) begin
            if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            else rdata_q <= we_q ? '0 : (rd_sel >> {addr_q[2:0], 3'b000}) & bit_mask(be_mask(size_q));
        end
    end

    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_fault = rsp_valid ? fault_q : FAULT_NONE;
    assign mem_sel = acc ? sel_oh : '0;
    assign mem_we = acc && we_q;
    assign mem_addr = acc ? {addr_q[31:3], 3'b000} : '0;
    assign mem_be = acc ? be_mask(size_q) << addr_q[2:0] : '0;
    assign mem_wdata = acc ? wdata_q << {addr_q[2:0], 3'b000} : '0;
endmodule

// File: doc/legv8_mem_bus_ctrl.md
LEGV8_MEM_BUS_CTRL -- requirements
Module: legv8_mem_bus_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REGIONS, default 2, giving the number of decoded memory regions (1..4).
REQ-002 The block SHALL have parameter REGION_BASE, NUM_REGIONS*32 bits, default {32'h40000000, 32'h60000000}, holding the base address per region (region 0 in the LSBs).
REQ-003 The block SHALL have parameter REGION_ABITS, NUM_REGIONS*8 bits, default {8'd10, 8'd12}, giving the byte-address width per region.
REQ-004 The block SHALL have parameter REGION_WAIT, NUM_REGIONS*4 bits, default {4'd1, 4'd0}, giving the wait states per region.
REQ-005 The block SHALL have parameter REGION_RO, NUM_REGIONS bits, default 2'b10, where each set bit marks a region read-only.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port req_valid, input, 1 bit, and port req_ready, output, 1 bit: the request handshake.
REQ-009 The block SHALL have port req_write, input, 1 bit, and port req_size, input, 2 bits: 0 byte, 1 half, 2 word, 3 dword.
REQ-010 The block SHALL have port req_addr, input, 32 bits, and port req_wdata, input, 64 bits, with write data right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit, and port rsp_ready, input, 1 bit: the response handshake.
REQ-012 The block SHALL have port rsp_rdata, output, 64 bits (zero-extended, right-aligned), and port rsp_fault, output, 2 bits.
REQ-013 The block SHALL have port mem_sel, output, NUM_REGIONS bits: a one-hot region chip select.
REQ-014 The block SHALL have port mem_we, output, 1 bit; port mem_addr, output, 32 bits (dword-aligned); port mem_be, output, 8 bits; port mem_wdata, output, 64 bits (lane-shifted).
REQ-015 The block SHALL have port mem_rdata, input, NUM_REGIONS*64 bits: read data per region.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 When IDLE and req_valid=1, the block SHALL latch the request at the clock edge and decode it.
- Hit: addr[31:ABITS_i] == BASE_i[31:ABITS_i].
- On overlapping hits, the lowest region index SHALL win.
REQ-018 Fault priority SHALL be: misaligned (addr mod 2^size != 0) 2'b01, then unmapped 2'b10, then write to an RO region 2'b11; a clean access SHALL report 2'b00.
REQ-019 A faulting request SHALL go directly to RESP, with no mem_sel assertion and rsp_rdata=0.
REQ-020 A clean request SHALL enter ACCESS with its wait counter set to WAIT_i.
- mem_sel[i], mem_addr, mem_be, mem_we and mem_wdata SHALL be held stable for WAIT_i+1 cycles.
- The counter SHALL decrement each cycle; at 0 the block SHALL capture mem_rdata[i] and go to RESP.
REQ-021 Latency: a request accepted at edge N SHALL give rsp_valid from cycle N+2+WAIT_i if clean, or from cycle N+1 if faulting.
REQ-022 The block SHALL set mem_be = ((1<<(1<<size))-1) << addr[2:0] and mem_wdata = req_wdata << (8*addr[2:0]).
REQ-023 The block SHALL form rsp_rdata by shifting the captured data right by 8*addr[2:0] and masking to the access size.
REQ-024 rsp_valid SHALL hold until rsp_ready=1; the block SHALL return to IDLE on that edge, and req_ready SHALL rise the following cycle.
REQ-025 Outside ACCESS, mem_sel, mem_we and mem_be SHALL be 0.

Reset
REQ-026 Reset SHALL force state IDLE, req_ready=1, and all other outputs and internal registers to 0, asynchronously.
REQ-027 Reset asserted mid-ACCESS or mid-RESP SHALL drop the transaction silently, with no response generated after release.

Structure
REQ-028 Package legv8_mem_pkg SHALL hold the size encodings, the fault codes (FAULT_NONE/MISALIGN/UNMAPPED/RO_WRITE) and the FSM state enum.
REQ-029 Region decode SHALL be one combinational sub-module, legv8_region_decoder, outputting the hit index, a hit flag and an RO flag.
REQ-030 The RTL SHALL be synthesizable with no tristate buffers; target size is 120-400 lines.

Verification
REQ-031 Directed: dword read of 0x60000008, mem_rdata[0]=0x1122334455667788 -> mem_sel=01 for 1 cycle; rsp_rdata=0x1122334455667788, fault 00, rsp_valid 2 cycles after acceptance.
REQ-032 Directed: byte write of 0xAB to 0x60000003 -> mem_be=0x08, mem_wdata[31:24]=0xAB, mem_we=1.
REQ-033 Directed: word read of 0x40000004 (WAIT=1), mem_rdata[1]=0xDEADBEEF00000000 -> mem_sel=10 for 2 cycles; rsp_rdata=0x00000000DEADBEEF.
REQ-034 Directed faults:
- half read of 0x60000001 -> fault 01;
- read of 0x50000000 -> fault 10;
- write to 0x40000000 -> fault 11;
- each with rsp_valid 1 cycle after acceptance and no mem_sel activity.
REQ-035 Directed: rsp_ready held 0 for 3 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0.
REQ-036 Directed: reset asserted during ACCESS -> outputs 0 immediately, no rsp_valid after release, next request served normally.
